// File: rtl/iddmm_final_sub.sv
// Final conditional subtraction of the IDDMM Montgomery multiplier: compares A with P,
// then streams R-P (R = carry*2^(K*N) + A) or A, one K-bit word per cycle, LS word first.
module iddmm_final_sub #(
    parameter int K      = 128,
    parameter int N      = 32,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              carry_in,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [K-1:0]      a_rd_data,
    input  logic [K-1:0]      p_rd_data,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_addr,
    output logic [K-1:0]      o_data,
    output logic              o_sub,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);

    // Handshake: start is a one-cycle request honoured only in IDLE (busy low);
    // o_valid qualifies o_addr/o_data for exactly one cycle with no back-pressure.
    typedef enum logic [1:0] {IDLE, CMP, SUB, DRAIN} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                carry_q, carry_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                rv_q, rv_d;
    logic                rsub_q, rsub_d;
    logic [ADDR_W-1:0]   ridx_q, ridx_d;
    logic                b_q, b_d;
    logic                bf_q, bf_d;
    logic                o_valid_q, o_valid_d;
    logic [ADDR_W-1:0]   o_addr_q, o_addr_d;
    logic [K-1:0]        o_data_q, o_data_d;
    logic                o_sub_q, o_sub_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [K:0]          diff;
    logic                sel;
    logic                last_word;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        rv_d      = rd_en_q;
        rsub_d    = (state_q == SUB);
        ridx_d    = rd_addr_q;
        b_d       = b_q;
        bf_d      = bf_q;
        o_valid_d = 1'b0;
        o_addr_d  = o_addr_q;
        o_data_d  = o_data_q;
        o_sub_d   = o_sub_q;
        done_d    = 1'b0;
        diff      = {1'b0, a_rd_data} - {1'b0, p_rd_data} - {{K{1'b0}}, b_q};
        sel       = carry_q | ~bf_q;
        last_word = (ridx_q == LAST);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CMP;
                    cnt_d   = '0;
                    carry_d = carry_in;
                    o_sub_d = 1'b0;
                    b_d     = 1'b0;
                    bf_d    = 1'b0;
                end
            end
            CMP: begin
                if (cnt_q == LAST) begin
                    state_d = SUB;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            SUB: begin
                if (cnt_q == LAST) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            DRAIN: begin
                if (cnt_q == ONE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        rd_en_d   = (state_d == CMP) || (state_d == SUB);
        rd_addr_d = rd_en_d ? cnt_d : '0;
        busy_d    = (state_d != IDLE);

        // RAM data is only looked at when the read-valid tag says it belongs to us;
        // the borrow chain is cleared after the last word of each pass.
        if (rv_q) begin
            b_d = last_word ? 1'b0 : diff[K];
            if (!rsub_q) begin
                if (last_word) begin
                    bf_d = diff[K];
                end
            end else begin
                o_valid_d = 1'b1;
                o_addr_d  = ridx_q;
                o_data_d  = sel ? diff[K-1:0] : a_rd_data;
                o_sub_d   = sel;
                done_d    = last_word;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rv_q      <= 1'b0;
            rsub_q    <= 1'b0;
            ridx_q    <= '0;
            b_q       <= 1'b0;
            bf_q      <= 1'b0;
            o_valid_q <= 1'b0;
            o_addr_q  <= '0;
            o_data_q  <= '0;
            o_sub_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            rv_q      <= rv_d;
            rsub_q    <= rsub_d;
            ridx_q    <= ridx_d;
            b_q       <= b_d;
            bf_q      <= bf_d;
            o_valid_q <= o_valid_d;
            o_addr_q  <= o_addr_d;
            o_data_q  <= o_data_d;
            o_sub_q   <= o_sub_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign o_valid   = o_valid_q;
    assign o_addr    = o_addr_q;
    assign o_data    = o_data_q;
    assign o_sub     = o_sub_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_iddmm_final_sub.sv
// Directed bench for iddmm_final_sub at K=8, N=4 with a synchronous RAM model
// that returns random garbage whenever rd_en is low.
module tb_iddmm_final_sub;

    localparam int K = 8;
    localparam int N = 4;
    localparam int AW = 2;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          carry_in;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [K-1:0]  a_rd_data;
    logic [K-1:0]  p_rd_data;
    logic          o_valid;
    logic [AW-1:0] o_addr;
    logic [K-1:0]  o_data;
    logic          o_sub;
    logic          busy;
    logic          done;
    logic [1:0]    dbg_state;

    logic [K-1:0]  a_mem [N];
    logic [K-1:0]  p_mem [N];

    int n_assert;
    int n_fail;

    iddmm_final_sub #(.K(K), .N(N), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .carry_in  (carry_in),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .a_rd_data (a_rd_data),
        .p_rd_data (p_rd_data),
        .o_valid   (o_valid),
        .o_addr    (o_addr),
        .o_data    (o_data),
        .o_sub     (o_sub),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous RAM model; garbage outside read cycles
    always @(posedge clk) begin
        if (rd_en) begin
            a_rd_data <= a_mem[rd_addr];
            p_rd_data <= p_mem[rd_addr];
        end else begin
            a_rd_data <= K'($urandom_range(0, 255));
            p_rd_data <= K'($urandom_range(0, 255));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd_en"},   32'(rd_en),   32'h0);
        check({tag, "_rd_addr"}, 32'(rd_addr), 32'h0);
        check({tag, "_o_valid"}, 32'(o_valid), 32'h0);
        check({tag, "_o_addr"},  32'(o_addr),  32'h0);
        check({tag, "_o_data"},  32'(o_data),  32'h0);
        check({tag, "_o_sub"},   32'(o_sub),   32'h0);
        check({tag, "_busy"},    32'(busy),    32'h0);
        check({tag, "_done"},    32'(done),    32'h0);
    endtask

    // One run; samples #1 after each edge E_e. poke_e >= 0 pulses start (with a
    // flipped carry_in) so it is sampled at E_poke_e; rst_e >= 0 asserts reset after E_rst_e.
    task automatic run_case(input string tag, input logic [31:0] a_val, input logic [31:0] p_val,
                            input logic cin, input logic [31:0] exp_r, input logic exp_sub,
                            input int poke_e, input int rst_e);
        int idx;
        for (int i = 0; i < N; i++) begin
            a_mem[i] = a_val[8*i +: 8];
            p_mem[i] = p_val[8*i +: 8];
        end
        @(negedge clk);
        carry_in = cin;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        carry_in = ~cin;
        for (int e = 0; e < 14; e++) begin
            start = 1'b0;
            if (e == rst_e) begin
                rst_n = 1'b0;
                #1;
                check_idle_outputs({tag, "_rst"});
                for (int c = 0; c < 12; c++) begin
                    @(posedge clk);
                    #1;
                    check({tag, "_rst_o_valid"}, 32'(o_valid), 32'h0);
                    check({tag, "_rst_done"},    32'(done),    32'h0);
                end
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            check({tag, "_busy"},  32'(busy),    32'((e <= 2*N + 1) ? 1 : 0));
            check({tag, "_rd_en"}, 32'(rd_en),   32'((e < 2*N) ? 1 : 0));
            if (e < 2*N) check({tag, "_rd_addr"}, 32'(rd_addr), 32'(e % N));
            check({tag, "_o_valid"}, 32'(o_valid), 32'((e >= N + 2 && e <= 2*N + 1) ? 1 : 0));
            check({tag, "_done"},    32'(done),    32'((e == 2*N + 1) ? 1 : 0));
            if (e >= N + 2 && e <= 2*N + 1) begin
                idx = e - (N + 2);
                check({tag, "_o_addr"}, 32'(o_addr), 32'(idx));
                check({tag, "_o_data"}, 32'(o_data), 32'(exp_r[8*idx +: 8]));
                check({tag, "_o_sub"},  32'(o_sub),  32'(exp_sub));
            end
            if (e + 1 == poke_e) begin
                start    = 1'b1;
                carry_in = ~cin;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        carry_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        check("reset_state", 32'(dbg_state), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // A < P: pass A through
        run_case("a_lt_p",   32'h01020304, 32'h01020305, 1'b0, 32'h01020304, 1'b0, -1, -1);
        // A == P: subtract to zero
        run_case("a_eq_p",   32'h80FF0011, 32'h80FF0011, 1'b0, 32'h00000000, 1'b1, -1, -1);
        // borrow ripples from word 0 through word 1
        run_case("borrow",   32'h00000100, 32'h000000FF, 1'b0, 32'h00000001, 1'b1, -1, -1);
        // carry forces subtraction: 2^32 + 0 - FFFFFFFF = 1
        run_case("carry",    32'h00000000, 32'hFFFFFFFF, 1'b1, 32'h00000001, 1'b1, -1, -1);
        // start pulsed at E5 with flipped carry: must not restart nor re-latch carry
        run_case("mid_start", 32'h01020304, 32'h01020305, 1'b0, 32'h01020304, 1'b0, 5, -1);
        check("mid_start_idle_valid", 32'(o_valid), 32'h0);
        check("mid_start_idle_busy",  32'(busy),    32'h0);
        // reset in the middle of a second run
        run_case("mid_rst",  32'h00000100, 32'h000000FF, 1'b0, 32'h00000001, 1'b1, -1, 5);
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("post_rst");
        // recovery after reset
        run_case("recover",  32'h00000000, 32'hFFFFFFFF, 1'b1, 32'h00000001, 1'b1, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
